// File: rtl/conv_pkg.sv
// Shared widths, layer-select codes and FSM state type for the convolution host responder.
package conv_pkg;
    localparam int DATA_W   = 20;
    localparam int ADDR_W   = 12;
    localparam int L1_DEPTH = 1024;
    localparam int L1_AW    = $clog2(L1_DEPTH);

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/conv_sram_1r1w.sv
// Single write port, registered read port; a same-address read and write returns the old word.
module conv_sram_1r1w #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 20,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic                     re,
    input  logic [AW-1:0]            raddr,
    output logic signed [DATA_W-1:0] q
);
    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is reset; array contents are left alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (re) q <= mem[raddr];
    end
endmodule

// File: rtl/conv_host_responder.sv
// Memory responder for the convolution engine: image/L0/L1 stores, start handshake,
// run watchdog and cycle counter, and a host load/readback port.
module conv_host_responder
    import conv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic                     busy,
    input  logic [ADDR_W-1:0]        iaddr,
    output logic signed [DATA_W-1:0] idata,
    input  logic                     cwr,
    input  logic [ADDR_W-1:0]        caddr_wr,
    input  logic signed [DATA_W-1:0] cdata_wr,
    input  logic                     crd,
    input  logic [ADDR_W-1:0]        caddr_rd,
    output logic signed [DATA_W-1:0] cdata_rd,
    input  logic [2:0]               csel,
    input  logic                     img_we,
    input  logic [ADDR_W-1:0]        img_waddr,
    input  logic signed [DATA_W-1:0] img_wdata,
    input  logic                     start,
    input  logic                     rb_rd,
    input  logic                     rb_sel,
    input  logic [ADDR_W-1:0]        rb_addr,
    output logic signed [DATA_W-1:0] rb_data,
    output logic                     done,
    output logic                     timeout,
    output logic                     err,
    output logic [31:0]              run_cycles
);
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t state;
    logic csel_l0, csel_l1, csel_ok, host_ok, host_l0, host_l1, set_err;
    logic [31:0] cycles_inc;
    logic signed [DATA_W-1:0] l0_q, l1_q;

    assign csel_l0 = (csel == CSEL_L0);
    assign csel_l1 = (csel == CSEL_L1);
    assign csel_ok = csel_l0 || csel_l1;
    assign host_ok = (state == IDLE) || (state == DONE);
    // The host owns a layer read port only while the engine is not running.
    assign host_l0 = host_ok && rb_rd && !rb_sel;
    assign host_l1 = host_ok && rb_rd && rb_sel;

    conv_sram_1r1w #(.DEPTH(1 << ADDR_W), .DATA_W(DATA_W)) u_img (
        .clk(clk), .reset(reset),
        .we(img_we && (state == IDLE)), .waddr(img_waddr), .wdata(img_wdata),
        .re(1'b1), .raddr(iaddr), .q(idata)
    );

    conv_sram_1r1w #(.DEPTH(1 << ADDR_W), .DATA_W(DATA_W)) u_l0 (
        .clk(clk), .reset(reset),
        .we(cwr && csel_l0), .waddr(caddr_wr), .wdata(cdata_wr),
        .re(host_l0 || (crd && csel_l0)), .raddr(host_l0 ? rb_addr : caddr_rd), .q(l0_q)
    );

    conv_sram_1r1w #(.DEPTH(L1_DEPTH), .DATA_W(DATA_W)) u_l1 (
        .clk(clk), .reset(reset),
        .we(cwr && csel_l1), .waddr(caddr_wr[L1_AW-1:0]), .wdata(cdata_wr),
        .re(host_l1 || (crd && csel_l1)),
        .raddr(host_l1 ? rb_addr[L1_AW-1:0] : caddr_rd[L1_AW-1:0]), .q(l1_q)
    );

    // Stage p1: read source tags travel with the registered SRAM word.
    logic eng_vld_p1, eng_l1_p1, eng_ok_p1, rb_vld_p1, rb_l1_p1, rb_ok_p1;
    logic signed [DATA_W-1:0] cdata_hold_p1, rb_hold_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_vld_p1    <= 1'b0;
            eng_l1_p1     <= 1'b0;
            eng_ok_p1     <= 1'b0;
            rb_vld_p1     <= 1'b0;
            rb_l1_p1      <= 1'b0;
            rb_ok_p1      <= 1'b0;
            cdata_hold_p1 <= '0;
            rb_hold_p1    <= '0;
        end else begin
            eng_vld_p1    <= crd;
            eng_l1_p1     <= csel_l1;
            eng_ok_p1     <= csel_ok;
            rb_vld_p1     <= rb_rd;
            rb_l1_p1      <= rb_sel;
            rb_ok_p1      <= host_ok;
            cdata_hold_p1 <= cdata_rd;
            rb_hold_p1    <= rb_data;
        end
    end

    always_comb begin
        cdata_rd = cdata_hold_p1;
        if (eng_vld_p1) cdata_rd = !eng_ok_p1 ? '0 : (eng_l1_p1 ? l1_q : l0_q);
        rb_data = rb_hold_p1;
        if (rb_vld_p1) rb_data = !rb_ok_p1 ? '0 : (rb_l1_p1 ? l1_q : l0_q);
    end

    assign set_err = (start && (state != IDLE))
                  || ((cwr || crd) && !csel_ok)
                  || (img_we && (state != IDLE))
                  || (rb_rd && !host_ok)
                  || (cwr && (state == IDLE));
    assign cycles_inc = sat_inc(run_cycles);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            err        <= 1'b0;
            run_cycles <= '0;
        end else begin
            // A new start wipes the sticky error, but a fault in the same cycle still lands.
            err <= set_err || (err && !((state == IDLE) && start));
            case (state)
                IDLE: if (start) begin
                    state      <= REQ;
                    ready      <= 1'b1;
                    timeout    <= 1'b0;
                    run_cycles <= '0;
                end
                REQ: if (busy) begin
                    state <= RUN;
                    ready <= 1'b0;
                end
                RUN: begin
                    run_cycles <= cycles_inc;
                    if (!busy) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (cycles_inc >= TIMEOUT_CYC) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
